cache_refill: RTL and testbench

Line-refill engine for the data cache. On a miss it fetches one 256-bit line from main memory as eight 32-bit beats, assembles the beats into a line buffer, and then issues a single-cycle write strobe. That strobe, together with the assembled line, drives the data array's full-line write path: hit low, every byte enable set.

---
 rtl/cache_refill.sv | 95 +++++++++
 tb/tb_cache_refill.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// Data-cache line refill engine: fetches a 256-bit line as eight 32-bit beats
// and issues a single-cycle full-line write strobe once the line is assembled.
module cache_refill #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata,
    output logic [255:0] line_out,
    output logic [31:0]  fill_addr,
    output logic         fill_we,
    output logic         busy,
    output logic         err
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    beat;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_inc;
    logic          timeout_hit;

    assign stall_inc   = stall_cnt + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (stall_inc == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (miss_req) state_next = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    if (beat == 3'd7) state_next = FILL;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            FILL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            stall_cnt <= '0;
            line_out  <= '0;
            fill_addr <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        fill_addr <= {miss_addr[31:5], 5'b0};
                        beat      <= '0;
                        stall_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        line_out[{beat, 5'b0} +: 32] <= mem_rdata;
                        beat      <= beat + 3'd1;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_inc;
                        err       <= timeout_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    // fill_addr keeps bits [4:0] zero, so splicing in the beat equals fill_addr + 4*beat
    assign mem_addr = {fill_addr[31:5], beat, 2'b00};
    assign mem_req  = (state == FETCH);
    assign fill_we  = (state == FILL);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_refill.sv
// Directed self-checking bench for cache_refill: a cycle table for the zero-wait
// refill plus hand-written sequences for stalls, timeout, busy requests and reset.
module tb_cache_refill;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_rdata = '0;

    logic         m_mem_req, t_mem_req, o_mem_req;
    logic [31:0]  m_mem_addr, t_mem_addr, o_mem_addr;
    logic [255:0] m_line_out, t_line_out, o_line_out;
    logic [31:0]  m_fill_addr, t_fill_addr, o_fill_addr;
    logic         m_fill_we, t_fill_we, o_fill_we;
    logic         m_busy, t_busy, o_busy;
    logic         m_err, t_err, o_err;
    logic         sel = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_refill dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_req(m_mem_req), .mem_addr(m_mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .line_out(m_line_out), .fill_addr(m_fill_addr),
        .fill_we(m_fill_we), .busy(m_busy), .err(m_err)
    );

    cache_refill #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .line_out(t_line_out), .fill_addr(t_fill_addr),
        .fill_we(t_fill_we), .busy(t_busy), .err(t_err)
    );

    assign o_mem_req   = sel ? t_mem_req   : m_mem_req;
    assign o_mem_addr  = sel ? t_mem_addr  : m_mem_addr;
    assign o_line_out  = sel ? t_line_out  : m_line_out;
    assign o_fill_addr = sel ? t_fill_addr : m_fill_addr;
    assign o_fill_we   = sel ? t_fill_we   : m_fill_we;
    assign o_busy      = sel ? t_busy      : m_busy;
    assign o_err       = sel ? t_err       : m_err;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_busy;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic rdy,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_addr, input logic e_we,
                                input logic e_busy, input logic [31:0] e_faddr);
        vec_t v;
        v.req = req; v.addr = addr; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we;
        v.e_busy = e_busy; v.e_faddr = e_faddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one refill from the acceptance edge to the first IDLE cycle after FILL.
    // intr_beat injects miss_req=0x2000 at that beat, pulsed or held per intr_hold.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] base,
                             input logic [7:0] stall_mask, input int nstall,
                             input int intr_beat, input bit intr_hold);
        logic [31:0]  la;
        logic [255:0] exp_line;
        la = {addr[31:5], 5'b0};
        exp_line = '0;
        miss_req = 1'b1; miss_addr = addr; mem_ready = 1'b0;
        step();
        miss_req = 1'b0;
        chk("acc busy", 256'(o_busy), 256'(1));
        chk("acc mem_req", 256'(o_mem_req), 256'(1));
        for (int k = 0; k < 8; k++) begin
            if (k == intr_beat) begin
                miss_req = 1'b1; miss_addr = 32'h2000;
            end
            if (stall_mask[k]) begin
                for (int s = 0; s < nstall; s++) begin
                    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
                    chk($sformatf("stall b%0d mem_addr", k), 256'(o_mem_addr), 256'(la + 4 * k));
                    chk($sformatf("stall b%0d fill_we", k), 256'(o_fill_we), 256'(0));
                    step();
                    if (!intr_hold) miss_req = 1'b0;
                end
            end
            chk($sformatf("b%0d mem_addr", k), 256'(o_mem_addr), 256'(la + 4 * k));
            chk($sformatf("b%0d mem_req", k), 256'(o_mem_req), 256'(1));
            chk($sformatf("b%0d fill_we", k), 256'(o_fill_we), 256'(0));
            mem_ready = 1'b1;
            mem_rdata = base + k;
            exp_line[32 * k +: 32] = base + k;
            step();
            if (!intr_hold) miss_req = 1'b0;
        end
        mem_ready = 1'b0;
        chk("fill fill_we", 256'(o_fill_we), 256'(1));
        chk("fill mem_req", 256'(o_mem_req), 256'(0));
        chk("fill busy", 256'(o_busy), 256'(1));
        chk("fill line_out", o_line_out, exp_line);
        chk("fill fill_addr", 256'(o_fill_addr), 256'(la));
        step();
        chk("post fill_we", 256'(o_fill_we), 256'(0));
        chk("post busy", 256'(o_busy), 256'(0));
        chk("post err", 256'(o_err), 256'(0));
        chk("post line_out", o_line_out, exp_line);
    endtask

    initial begin
        logic [255:0] line1;

        tbl[0] = mk(1'b1, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h1220, 1'b0, 1'b1, 32'h1220);
        for (int k = 0; k < 8; k++)
            tbl[k + 1] = mk(1'b0, 32'h0, 1'b1, 32'hA0 + k, (k < 7),
                            (k < 7) ? 32'h1220 + 4 * (k + 1) : 32'h1220,
                            (k == 7), 1'b1, 32'h1220);
        tbl[9] = mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1220, 1'b0, 1'b0, 32'h1220);
        line1 = '0;
        for (int k = 0; k < 8; k++) line1[32 * k +: 32] = 32'hA0 + k;

        // reset values
        step(); step();
        chk("rst mem_req", 256'(o_mem_req), 256'(0));
        chk("rst mem_addr", 256'(o_mem_addr), 256'(0));
        chk("rst line_out", o_line_out, 256'(0));
        chk("rst fill_addr", 256'(o_fill_addr), 256'(0));
        chk("rst fill_we", 256'(o_fill_we), 256'(0));
        chk("rst busy", 256'(o_busy), 256'(0));
        chk("rst err", 256'(o_err), 256'(0));
        reset = 1'b1;
        step();

        // zero-wait refill, one table row per cycle
        for (int i = 0; i < 10; i++) begin
            miss_req = tbl[i].req; miss_addr = tbl[i].addr;
            mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
            step();
            chk($sformatf("v%0d mem_req", i), 256'(o_mem_req), 256'(tbl[i].e_req));
            chk($sformatf("v%0d mem_addr", i), 256'(o_mem_addr), 256'(tbl[i].e_addr));
            chk($sformatf("v%0d fill_we", i), 256'(o_fill_we), 256'(tbl[i].e_we));
            chk($sformatf("v%0d busy", i), 256'(o_busy), 256'(tbl[i].e_busy));
            chk($sformatf("v%0d fill_addr", i), 256'(o_fill_addr), 256'(tbl[i].e_faddr));
            chk($sformatf("v%0d err", i), 256'(o_err), 256'(0));
        end
        chk("zw line_out", o_line_out, line1);

        // mem_ready while IDLE must not disturb anything
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; mem_rdata = $urandom;
            step();
            chk("idle line_out", o_line_out, line1);
            chk("idle busy", 256'(o_busy), 256'(0));
            chk("idle mem_req", 256'(o_mem_req), 256'(0));
            chk("idle fill_we", 256'(o_fill_we), 256'(0));
            chk("idle fill_addr", 256'(o_fill_addr), 256'(32'h1220));
        end
        mem_ready = 1'b0;

        // stalled beats 2 and 5, three cycles each
        do_refill(32'h1234, 32'hA0, 8'b0010_0100, 3, -1, 1'b0);

        // pulsed request during FETCH is dropped; held request is taken after FILL
        do_refill(32'h1234, 32'hB0, 8'h00, 0, 2, 1'b0);
        do_refill(32'h1234, 32'hC0, 8'h00, 0, 4, 1'b1);
        do_refill(32'h2000, 32'hE0, 8'h00, 0, -1, 1'b0);

        // reset after beat 4
        miss_req = 1'b1; miss_addr = 32'h4000;
        step();
        miss_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1'b1; mem_rdata = 32'h70 + k;
            step();
        end
        reset = 1'b0; mem_ready = 1'b0;
        step();
        chk("mrst mem_req", 256'(o_mem_req), 256'(0));
        chk("mrst busy", 256'(o_busy), 256'(0));
        chk("mrst line_out", o_line_out, 256'(0));
        chk("mrst fill_addr", 256'(o_fill_addr), 256'(0));
        chk("mrst fill_we", 256'(o_fill_we), 256'(0));
        chk("mrst err", 256'(o_err), 256'(0));
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mrst2 fill_we", 256'(o_fill_we), 256'(0));
            chk("mrst2 err", 256'(o_err), 256'(0));
            chk("mrst2 busy", 256'(o_busy), 256'(0));
        end
        do_refill(32'h5678, 32'h90, 8'h00, 0, -1, 1'b0);

        // timeout on the TIMEOUT=4 instance: mem_ready stuck low after beat 3
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        sel = 1'b1;
        miss_req = 1'b1; miss_addr = 32'h1234;
        step();
        miss_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1; mem_rdata = 32'h10 + k;
            step();
        end
        mem_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step();
            chk("to stall busy", 256'(o_busy), 256'(1));
            chk("to stall mem_req", 256'(o_mem_req), 256'(1));
            chk("to stall err", 256'(o_err), 256'(0));
        end
        step();
        chk("to err", 256'(o_err), 256'(1));
        chk("to mem_req", 256'(o_mem_req), 256'(0));
        chk("to busy", 256'(o_busy), 256'(0));
        chk("to fill_we", 256'(o_fill_we), 256'(0));
        step();
        chk("to err clear", 256'(o_err), 256'(0));
        chk("to fill_we2", 256'(o_fill_we), 256'(0));
        do_refill(32'h0880, 32'h30, 8'h00, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
